// File: rtl/colour_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : colour_arbiter
//  Description : Two-requester round-robin arbiter in front of the shared RGB
//                colour converter. Grants one requester at a time for a fixed
//                HOLD-cycle window, drives the converter's colour/enable, and
//                pulses done when a window completes without abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module colour_arbiter #(
    parameter int HOLD  = 4,   // grant length in cycles, 1..255
    parameter int CNT_W = 8    // hold counter width, must hold HOLD-1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] colour0,
    input  logic       req1,
    input  logic [2:0] colour1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [2:0] colour,
    output logic       enable,
    output logic       done
);

    // Counter preload: the window is HOLD edges long, the last one seeing 0.
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q,   ptr_d;     // last winner: 0 or 1
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // cycles left after the current one
    logic [2:0]       colour_q, colour_d;
    logic             gnt0_q,  gnt0_d;
    logic             gnt1_q,  gnt1_d;
    logic             en_q,    en_d;
    logic             done_q,  done_d;

    logic             w_win0;
    logic             w_win1;
    logic             w_owner_req;

    // A single request wins outright; on contention the one that did not
    // win last time takes the converter.
    assign w_win0 = req0 & (~req1 | ptr_q);
    assign w_win1 = req1 & (~req0 | ~ptr_q);

    // Only the current owner's request can keep a grant alive.
    assign w_owner_req = gnt1_q ? req1 : req0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        en_d     = en_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                en_d   = 1'b0;
                if (w_win0) begin
                    colour_d = colour0;
                    gnt0_d   = 1'b1;
                    en_d     = 1'b1;
                    cnt_d    = C_LOAD;
                    ptr_d    = 1'b0;
                    state_d  = S_GRANT;
                end else if (w_win1) begin
                    colour_d = colour1;
                    gnt1_d   = 1'b1;
                    en_d     = 1'b1;
                    cnt_d    = C_LOAD;
                    ptr_d    = 1'b1;
                    state_d  = S_GRANT;
                end
            end

            S_GRANT: begin
                if (!w_owner_req) begin
                    // Abort wins over expiry: release without done.
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == C_ZERO) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end

            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears outputs without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b1;
            cnt_q    <= C_ZERO;
            colour_q <= 3'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign colour = colour_q;
    assign enable = en_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: doc/colour_arbiter.md
# colour_arbiter

Two-requester round-robin arbiter that shares the single RGB colour converter between independent colour sources. Owns the converter's `colour` and `enable` inputs, grants one requester at a time for a fixed hold window, and signals completion. Sits directly upstream of the converter; requesters never drive the converter themselves.

## Interface

- `HOLD`, default 4: grant length in clock cycles; legal range 1..255.
- `CNT_W`, default 8: width of the hold counter; must hold `HOLD-1`.

Ports:

- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0`  in  1  requester 0 wants the converter.
- `colour0`  in  3  requester 0 colour code.
- `req1`  in  1  requester 1 wants the converter.
- `colour1`  in  3  requester 1 colour code.
- `gnt0`  out  1  requester 0 owns the converter.
- `gnt1`  out  1  requester 1 owns the converter.
- `colour`  out  3  colour code to converter.
- `enable`  out  1  converter enable.
- `done`  out  1  one-cycle pulse when a grant completes its full `HOLD` window.

## Operation

- All outputs are registered. The reset value of every output is 0.
- The last-winner pointer resets to 1, so requester 0 wins the first contention.
- States: `IDLE`, `GRANT`.
- **IDLE:** `gnt0` = `gnt1` = `enable` = 0.
  - If only one request is high at an edge, that requester wins.
  - If both are high, the requester not equal to the last winner wins.
  - On a win, at that edge:
    - the winner's `colourN` is latched into `colour`;
    - `enable` is set to 1;
    - `gntN` is set to 1;
    - the counter is loaded with `HOLD-1`;
    - the pointer is set to the winner;
    - the state moves to `GRANT`.
  - If no request is high, all outputs hold 0 (`colour` keeps its last value).
- **GRANT:** the counter decrements each edge.
  - Normal completion: at the edge where the counter is 0, `gnt`/`enable` clear, `done` is set for one cycle, and the state moves to `IDLE`.
  - Abort: if the owner's `reqN` is low at any `GRANT` edge, the same clear happens at that edge with `done` left at 0, and the state moves to `IDLE`. Abort takes priority over expiry when both occur at the same edge.
  - `colourN` changes during `GRANT` are ignored; the latched `colour` stays stable for the whole window.
  - The non-owner's `req` is ignored until `IDLE`.
- `gnt0` and `gnt1` are never both high.
- `done` is never high while any `gnt` is high.
- `HOLD` = 1 boundary: the grant lasts exactly one cycle and `done` follows in the next cycle.
- Reset mid-grant: all outputs go to 0 immediately without a clock edge. The state returns to `IDLE` and the pointer to 1.

## Timing

- Grant latency: a request sampled high at edge N in `IDLE` gives `gntN`, `enable` and `colour` valid from edge N, i.e. visible in cycle N+1.
- Grant duration: exactly `HOLD` cycles unless aborted.
- `done` is high for exactly 1 cycle, the first `IDLE` cycle after expiry.
- There is a minimum of 1 `IDLE` cycle between consecutive grants. Back-to-back contention therefore gives a period of `HOLD+1` cycles per grant.
- Abort latency: `reqN` low sampled at edge M means `gntN` is low from edge M.
- The converter samples `colour`/`enable` on `clk`. Its `rgb` output is valid from the second cycle of the grant through the end of the grant.

## Test plan

1. **Reset:** assert `rst` mid-simulation with no clock edge. Required: `gnt0`, `gnt1`, `enable`, `done`, `colour` all 0 within the same timestep.
2. **Single request:** `HOLD`=4, `req0`=1, `colour0`=5. Required:
   - `gnt0`=1, `enable`=1, `colour`=5 for exactly 4 cycles, starting 1 cycle after `req0` is sampled;
   - `done`=1 for 1 cycle afterwards;
   - converter `rgb`=24'hFF00FF during the grant.
3. **Contention:** `req0` and `req1` held high, `colour0`=3, `colour1`=6. Required:
   - grants alternate 0,1,0,1;
   - each grant lasts 4 cycles, followed by 1 idle cycle with `done`=1;
   - `colour` sequence is 3,6,3,6;
   - `rgb` sequence is 24'h00FFFF, 24'hFFFF00.
4. **Abort:** `req1` only, then drop `req1` in the 2nd grant cycle. Required: `gnt1`=0 and `enable`=0 from the next edge; `done` stays 0; a pending `req0` is granted one cycle later.
5. **Colour stability:** `colour0` changes from 2 to 7 mid-grant. Required: `colour` stays 2 and `rgb` stays 24'h00FF00 until the grant ends.
6. **Reset mid-grant, then contention:** reset during a `gnt1` window, release, then raise both requests with `colour0`=1, `colour1`=4. Required: `gnt0` is granted first and `rgb`=24'h0000FF.
